// File: rtl/disp_rx_pkg.sv
// Shared types and constants for the receive/display block.
// ASCII hex ranges, digit type and decode mode.
package disp_rx_pkg;

  localparam int DIG_W = 4;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_UF = 8'h46;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LF = 8'h66;

  typedef logic [DIG_W-1:0] digit_t;

  typedef enum logic {
    RX_ASCII = 1'b0,
    RX_RAW   = 1'b1
  } rx_mode_e;

endpackage

// File: rtl/rx_sym_decode.sv
// Combinational byte to hex digit decoder.
// ASCII hex or raw low nibble, selected by mode.
module rx_sym_decode
  import disp_rx_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0] i_byte,
  input  rx_mode_e        i_mode,
  output logic            o_valid,
  output digit_t          o_digit
);

  logic [7:0] w_lo;
  logic       w_hi;
  logic       w_num;
  logic       w_let;

  assign w_lo = i_byte[7:0];

  generate
    if (IN_W > 8) begin : g_hi
      assign w_hi = |i_byte[IN_W-1:8];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  assign w_num = (w_lo >= ASC_0) && (w_lo <= ASC_9);
  assign w_let = ((w_lo >= ASC_UA) && (w_lo <= ASC_UF))
              || ((w_lo >= ASC_LA) && (w_lo <= ASC_LF));

  // Letters map via low nibble + 9 ('A'=0x41 -> 10).
  always_comb begin
    o_valid = 1'b0;
    o_digit = '0;
    if (i_mode == RX_RAW) begin
      o_valid = 1'b1;
      o_digit = digit_t'(i_byte[3:0]);
    end else if (!w_hi) begin
      unique case (1'b1)
        w_num: begin
          o_valid = 1'b1;
          o_digit = digit_t'(w_lo[3:0]);
        end
        w_let: begin
          o_valid = 1'b1;
          o_digit = digit_t'(w_lo[3:0] + 4'd9);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/disp_rx_shift.sv
// Strobe-edge byte capture shifted into an N-digit display.
// Per-digit/global clear, valid mask, count, err/ovf pulses.
module disp_rx_shift
  import disp_rx_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IN_W       = 8,
  parameter int DIG_W      = 4,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic                        gen_in,
  input  logic                        Reset,
  input  logic [IN_W-1:0]             inp,
  input  logic                        priem_in,
  input  logic                        mode,
  input  logic                        clear_disp,
  input  logic [NUM_DIGITS-1:0]       dig_reset,
  output logic [NUM_DIGITS*DIG_W-1:0] disp,
  output logic [NUM_DIGITS-1:0]       valid_mask,
  output logic [CW-1:0]               count,
  output logic                        err,
  output logic                        ovf
);

  logic                        r_prev;
  logic [NUM_DIGITS*DIG_W-1:0] r_disp;
  logic [NUM_DIGITS-1:0]       r_vmask;
  logic [CW-1:0]               r_count;
  logic                        r_err;
  logic                        r_ovf;

  logic                        w_edge;
  logic                        w_valid;
  logic                        w_acc;
  logic                        w_rej;
  digit_t                      w_dig;
  logic [NUM_DIGITS*DIG_W-1:0] w_disp_n;
  logic [NUM_DIGITS-1:0]       w_vm_n;
  logic [CW-1:0]               w_cnt_n;

  rx_sym_decode #(
    .IN_W (IN_W)
  ) u_dec (
    .i_byte  (inp),
    .i_mode  (rx_mode_e'(mode)),
    .o_valid (w_valid),
    .o_digit (w_dig)
  );

  assign w_edge = priem_in & ~r_prev;
  assign w_acc  = w_edge & w_valid;
  assign w_rej  = w_edge & ~w_valid;

  // Shift on accept, then apply per-digit clears; count follows mask.
  always_comb begin
    w_disp_n = r_disp;
    w_vm_n   = r_vmask;
    w_cnt_n  = '0;
    if (w_acc) begin
      w_disp_n = {r_disp[(NUM_DIGITS-1)*DIG_W-1:0], w_dig};
      w_vm_n   = {r_vmask[NUM_DIGITS-2:0], 1'b1};
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_reset[i]) begin
        w_disp_n[i*DIG_W +: DIG_W] = '0;
        w_vm_n[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_cnt_n = w_cnt_n + {{(CW-1){1'b0}}, w_vm_n[i]};
    end
  end

  // State update; prev resets high so a held strobe is not an edge.
  always_ff @(posedge gen_in) begin
    if (!Reset) begin
      r_prev  <= 1'b1;
      r_disp  <= '0;
      r_vmask <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_prev <= priem_in;
      r_err  <= 1'b0;
      r_ovf  <= 1'b0;
      if (clear_disp) begin
        r_disp  <= '0;
        r_vmask <= '0;
        r_count <= '0;
      end else begin
        r_disp  <= w_disp_n;
        r_vmask <= w_vm_n;
        r_count <= w_cnt_n;
        r_err   <= w_rej;
        r_ovf   <= w_acc & r_vmask[NUM_DIGITS-1];
      end
    end
  end

  assign disp       = r_disp;
  assign valid_mask = r_vmask;
  assign count      = r_count;
  assign err        = r_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_disp_rx_shift.sv
// Bench for disp_rx_shift: digit-array model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_disp_rx_shift;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int DW = 4;
  localparam int CW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IW-1:0]   inp = '0;
  logic            pr = 1'b0;
  logic            mode = 1'b0;
  logic            clr = 1'b0;
  logic [N-1:0]    dr = '0;
  logic [N*DW-1:0] disp;
  logic [N-1:0]    vmask;
  logic [CW-1:0]   count;
  logic            err;
  logic            ovf;

  int checks = 0;
  int errors = 0;
  int e_cnt  = 0;
  int o_cnt  = 0;

  int m_d [N];
  int m_v [N];
  int m_prev = 1;
  int m_err  = 0;
  int m_ovf  = 0;

  disp_rx_shift #(
    .NUM_DIGITS (N),
    .IN_W       (IW),
    .DIG_W      (DW)
  ) dut (
    .gen_in     (clk),
    .Reset      (rst_n),
    .inp        (inp),
    .priem_in   (pr),
    .mode       (mode),
    .clear_disp (clr),
    .dig_reset  (dr),
    .disp       (disp),
    .valid_mask (vmask),
    .count      (count),
    .err        (err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic int decode(input int b, input int m, output int ok);
    ok = 1;
    if (m == 1) return b % 16;
    if (b >= "0" && b <= "9") return b - "0";
    if (b >= "A" && b <= "F") return b - "A" + 10;
    if (b >= "a" && b <= "f") return b - "a" + 10;
    ok = 0;
    return 0;
  endfunction

  task automatic model_step();
    int ed, ok, val;
    if (!rst_n) begin
      foreach (m_d[i]) begin m_d[i] = 0; m_v[i] = 0; end
      m_prev = 1; m_err = 0; m_ovf = 0;
      return;
    end
    ed = (pr && !m_prev) ? 1 : 0;
    m_prev = pr ? 1 : 0;
    m_err = 0;
    m_ovf = 0;
    if (clr) begin
      foreach (m_d[i]) begin m_d[i] = 0; m_v[i] = 0; end
      return;
    end
    if (ed == 1) begin
      val = decode(int'(inp), int'(mode), ok);
      if (ok == 1) begin
        m_ovf = m_v[N-1];
        for (int i = N - 1; i > 0; i--) begin
          m_d[i] = m_d[i-1];
          m_v[i] = m_v[i-1];
        end
        m_d[0] = val;
        m_v[0] = 1;
      end else begin
        m_err = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (dr[i]) begin m_d[i] = 0; m_v[i] = 0; end
    end
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int ed, ev, ec;
    ed = 0; ev = 0; ec = 0;
    for (int i = 0; i < N; i++) begin
      ed = ed + (m_d[i] << (i * DW));
      ev = ev + (m_v[i] << i);
      ec = ec + m_v[i];
    end
    cmp("disp", int'(disp), ed);
    cmp("valid_mask", int'(vmask), ev);
    cmp("count", int'(count), ec);
    cmp("err", int'(err), m_err);
    cmp("ovf", int'(ovf), m_ovf);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
    e_cnt += int'(err);
    o_cnt += int'(ovf);
  endtask

  task automatic strobe(input logic [7:0] b);
    inp = b;
    pr = 1'b1;
    tick();
    pr = 1'b0;
    tick();
  endtask

  initial begin
    // reset
    tick();
    tick();
    cmp("rst_disp", int'(disp), 0);
    cmp("rst_count", int'(count), 0);
    rst_n = 1'b1;
    tick();

    // ASCII sequence with rejects
    mode = 1'b0;
    e_cnt = 0; o_cnt = 0;
    strobe(8'h33); strobe(8'h1B); strobe(8'h5B);
    strobe(8'h41); strobe(8'h20); strobe(8'h37);
    cmp("t1_err_pulses", e_cnt, 3);
    cmp("t1_ovf_pulses", o_cnt, 0);
    cmp("t1_disp", int'(disp), 'h03A7);
    cmp("t1_mask", int'(vmask), 'b0111);
    cmp("t1_count", int'(count), 3);

    // clear on the same cycle as a valid edge
    e_cnt = 0; o_cnt = 0;
    clr = 1'b1; inp = 8'h41; pr = 1'b1;
    tick();
    clr = 1'b0; pr = 1'b0;
    tick();
    cmp("clr_disp", int'(disp), 0);
    cmp("clr_mask", int'(vmask), 0);
    cmp("clr_count", int'(count), 0);
    cmp("clr_noerr", e_cnt + o_cnt, 0);

    // raw mode and wrap-around
    mode = 1'b1;
    strobe(8'h33); strobe(8'h1B); strobe(8'h5B); strobe(8'h41);
    cmp("raw4_disp", int'(disp), 'h3BB1);
    cmp("raw4_count", int'(count), 4);
    o_cnt = 0;
    strobe(8'h20);
    cmp("wrap_disp", int'(disp), 'hBB10);
    cmp("wrap_count", int'(count), 4);
    cmp("wrap_ovf", o_cnt, 1);

    // held strobe gives one accept
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b0; inp = 8'h37; pr = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    cmp("hold_disp", int'(disp), 'h0007);
    cmp("hold_count", int'(count), 1);
    pr = 1'b0; tick();
    strobe(8'h37);
    cmp("rehit_disp", int'(disp), 'h0077);
    cmp("rehit_count", int'(count), 2);

    // per-digit clear together with an accept
    clr = 1'b1; tick(); clr = 1'b0;
    strobe(8'h33); strobe(8'h41);
    cmp("pre_dr_disp", int'(disp), 'h003A);
    dr = 4'b0001; inp = 8'h35; pr = 1'b1;
    tick();
    dr = '0; pr = 1'b0;
    tick();
    cmp("dr_disp", int'(disp), 'h03A0);
    cmp("dr_mask", int'(vmask), 'b0110);
    cmp("dr_count", int'(count), 2);

    // reset with strobe held high
    pr = 1'b1; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    cmp("rsthold_disp", int'(disp), 0);
    cmp("rsthold_mask", int'(vmask), 0);
    cmp("rsthold_count", int'(count), 0);
    pr = 1'b0; tick();
    strobe(8'h39);
    cmp("post_rst_disp", int'(disp), 'h0009);
    cmp("post_rst_count", int'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
